// File: rtl/kbd_player_controller.sv
// Keyboard command decoder and playback-control FSM for the flash player.
// Turns one key press into one track/direction/pause/speed/restart action.
module kbd_player_controller #(
    parameter int                ADDR_W           = 23,
    parameter int                NUM_TRACKS       = 4,
    parameter logic [ADDR_W-1:0] TRACK_SPAN       = 23'h80000,
    parameter int                RST_PULSE_CYCLES = 2,
    parameter int                SPEED_LEVELS     = 4,
    localparam int TRACK_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
    localparam int SPEED_W = $clog2(SPEED_LEVELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               kbd_data_ready,
    input  logic [7:0]         kbd_code,
    output logic [TRACK_W-1:0] track_sel,
    output logic [ADDR_W-1:0]  start_addr,
    output logic [ADDR_W-1:0]  end_addr,
    output logic               direction,
    output logic               pause,
    output logic [SPEED_W-1:0] speed_sel,
    output logic               restart,
    output logic               cmd_strobe
);

    localparam int CNT_W = $clog2(RST_PULSE_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_PULSE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    localparam logic [3:0] C_NONE = 4'd0;
    localparam logic [3:0] C_R    = 4'd1;
    localparam logic [3:0] C_D    = 4'd2;
    localparam logic [3:0] C_E    = 4'd3;
    localparam logic [3:0] C_B    = 4'd4;
    localparam logic [3:0] C_F    = 4'd5;
    localparam logic [3:0] C_N    = 4'd6;
    localparam logic [3:0] C_P    = 4'd7;
    localparam logic [3:0] C_U    = 4'd8;
    localparam logic [3:0] C_S    = 4'd9;

    localparam logic [TRACK_W-1:0] TRK_LAST = TRACK_W'(NUM_TRACKS - 1);
    localparam logic [SPEED_W-1:0] SPD_LAST = SPEED_W'(SPEED_LEVELS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RST_PULSE_CYCLES - 1);

    logic               rdy_m;
    logic               rdy_s;
    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [7:0]         code_q;
    logic [3:0]         cmd_q;
    logic [3:0]         cmd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmd_restarts;
    logic [TRACK_W-1:0] nxt_track;
    logic               nxt_dir;
    logic               nxt_pause;
    logic [SPEED_W-1:0] nxt_speed;
    logic [ADDR_W-1:0]  nxt_base;
    logic [ADDR_W-1:0]  nxt_top;

    // Bring the asynchronous ready flag into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= kbd_data_ready;
            rdy_s <= rdy_m;
        end
    end

    // Map the captured scan code onto a command id.
    always_comb begin
        cmd_d = C_NONE;
        unique case (1'b1)
            (code_q == 8'h2D): cmd_d = C_R;
            (code_q == 8'h23): cmd_d = C_D;
            (code_q == 8'h24): cmd_d = C_E;
            (code_q == 8'h32): cmd_d = C_B;
            (code_q == 8'h2B): cmd_d = C_F;
            (code_q == 8'h31): cmd_d = C_N;
            (code_q == 8'h4D): cmd_d = C_P;
            (code_q == 8'h3C): cmd_d = C_U;
            (code_q == 8'h1B): cmd_d = C_S;
            default:           cmd_d = C_NONE;
        endcase
    end

    assign cmd_restarts = (cmd_q == C_R) || (cmd_q == C_B) ||
                          (cmd_q == C_F) || (cmd_q == C_N) ||
                          (cmd_q == C_P);

    // Next-state logic: one command per ready-high period.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (rdy_s) state_d = S_DECODE;
            S_DECODE: state_d = (cmd_d != C_NONE) ? S_EXEC : S_WAIT;
            S_EXEC:   state_d = cmd_restarts ? S_PULSE : S_WAIT;
            S_PULSE:  if (cnt_q == CNT_LAST) state_d = S_WAIT;
            S_WAIT:   if (!rdy_s) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM state, code capture, decoded command and pulse width counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= 8'h00;
            cmd_q   <= C_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && rdy_s) code_q <= kbd_code;
            if (state_q == S_DECODE) cmd_q <= cmd_d;
            if (state_q == S_PULSE) cnt_q <= cnt_q + CNT_W'(1);
            else cnt_q <= '0;
        end
    end

    // Apply the decoded command to the control settings while in EXEC.
    always_comb begin
        nxt_track = track_sel;
        nxt_dir   = direction;
        nxt_pause = pause;
        nxt_speed = speed_sel;
        if (state_q == S_EXEC) begin
            unique case (cmd_q)
                C_D: nxt_pause = 1'b1;
                C_E: nxt_pause = 1'b0;
                C_B: nxt_dir = 1'b0;
                C_F: nxt_dir = 1'b1;
                C_N: nxt_track = (track_sel == TRK_LAST) ? '0
                               : track_sel + TRACK_W'(1);
                C_P: nxt_track = (track_sel == '0) ? TRK_LAST
                               : track_sel - TRACK_W'(1);
                C_U: if (speed_sel != SPD_LAST)
                         nxt_speed = speed_sel + SPEED_W'(1);
                C_S: if (speed_sel != '0)
                         nxt_speed = speed_sel - SPEED_W'(1);
                default: ;
            endcase
        end
    end

    assign nxt_base = ADDR_W'(nxt_track) * TRACK_SPAN;
    assign nxt_top  = nxt_base + TRACK_SPAN - ADDR_W'(1);

    // Register settings and the direction-dependent address window.
    always_ff @(posedge clk) begin
        if (reset) begin
            track_sel  <= '0;
            direction  <= 1'b1;
            pause      <= 1'b1;
            speed_sel  <= SPEED_W'(1);
            start_addr <= '0;
            end_addr   <= TRACK_SPAN - ADDR_W'(1);
        end else begin
            track_sel  <= nxt_track;
            direction  <= nxt_dir;
            pause      <= nxt_pause;
            speed_sel  <= nxt_speed;
            start_addr <= nxt_dir ? nxt_base : nxt_top;
            end_addr   <= nxt_dir ? nxt_top : nxt_base;
        end
    end

    assign restart    = (state_q == S_PULSE);
    assign cmd_strobe = (state_q == S_EXEC);

endmodule

// File: tb/tb_kbd_player_controller.sv
// Randomized bench for kbd_player_controller against a behavioural
// model of the player settings and the key-press timing.
module tb_kbd_player_controller;

    localparam int     NT   = 4;
    localparam int     SL   = 4;
    localparam int     RPC  = 2;
    localparam int     AW   = 23;
    localparam longint SPAN = 64'h80000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdy = 1'b0;
    logic [7:0]  code = 8'h00;
    logic [1:0]  track_sel;
    logic [22:0] start_addr;
    logic [22:0] end_addr;
    logic        direction;
    logic        pause;
    logic [1:0]  speed_sel;
    logic        restart;
    logic        cmd_strobe;

    int n_chk = 0;
    int n_fail = 0;

    int m_track;
    bit m_dir;
    bit m_pause;
    int m_speed;

    logic [7:0] codes [9] = '{8'h2D, 8'h23, 8'h24, 8'h32, 8'h2B,
                              8'h31, 8'h4D, 8'h3C, 8'h1B};

    kbd_player_controller dut (
        .clk            (clk),
        .reset          (reset),
        .kbd_data_ready (rdy),
        .kbd_code       (code),
        .track_sel      (track_sel),
        .start_addr     (start_addr),
        .end_addr       (end_addr),
        .direction      (direction),
        .pause          (pause),
        .speed_sel      (speed_sel),
        .restart        (restart),
        .cmd_strobe     (cmd_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_regs();
        return 64'({track_sel, start_addr, end_addr,
                    direction, pause, speed_sel});
    endfunction

    function automatic logic [63:0] exp_regs();
        longint      base;
        longint      top;
        logic [22:0] s;
        logic [22:0] e;
        base = (longint'(m_track) * SPAN) % (longint'(1) << AW);
        top  = (base + SPAN - 1) % (longint'(1) << AW);
        s = m_dir ? 23'(base) : 23'(top);
        e = m_dir ? 23'(top) : 23'(base);
        return 64'({2'(m_track), s, e, m_dir, m_pause, 2'(m_speed)});
    endfunction

    function automatic void model_reset();
        m_track = 0;
        m_dir   = 1'b1;
        m_pause = 1'b1;
        m_speed = 1;
    endfunction

    task automatic model_apply(input logic [7:0] c, output bit rec,
                               output bit rs);
        rec = 1'b1;
        rs  = 1'b0;
        case (c)
            8'h2D: rs = 1'b1;
            8'h23: m_pause = 1'b1;
            8'h24: m_pause = 1'b0;
            8'h32: begin m_dir = 1'b0; rs = 1'b1; end
            8'h2B: begin m_dir = 1'b1; rs = 1'b1; end
            8'h31: begin m_track = (m_track + 1) % NT; rs = 1'b1; end
            8'h4D: begin m_track = (m_track + NT - 1) % NT; rs = 1'b1; end
            8'h3C: if (m_speed < SL - 1) m_speed++;
            8'h1B: if (m_speed > 0) m_speed--;
            default: rec = 1'b0;
        endcase
    endtask

    // Called at a negedge; ready is raised immediately and held for
    // 'hold' clock edges. Ends at a negedge.
    task automatic press(input logic [7:0] c, input int hold);
        logic [63:0] old_r;
        logic [63:0] new_r;
        bit          rec;
        bit          rs;
        int          w;
        old_r = exp_regs();
        model_apply(c, rec, rs);
        new_r = exp_regs();
        w = ((hold > 7) ? hold : 7) + 1;
        code = c;
        rdy  = 1'b1;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk("strobe", 64'(cmd_strobe), 64'(rec && i == 3));
            chk("restart", 64'(restart), 64'(rs && i >= 4 && i < 4 + RPC));
            chk("regs", dut_regs(), (i < 4) ? old_r : new_r);
            if (i == hold - 1) rdy = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_strobe", 64'(cmd_strobe), 64'(0));
            chk("idle_restart", 64'(restart), 64'(0));
            chk("idle_regs", dut_regs(), new_r);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rdy   = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        chk("rst_regs", dut_regs(), exp_regs());
        chk("rst_strobe", 64'(cmd_strobe), 64'(0));
        chk("rst_restart", 64'(restart), 64'(0));
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        @(negedge clk);
        do_reset();
        press(8'h24, 10);
        press(8'h32, 3);
        repeat (4) press(8'h31, 2);
        press(8'h4D, 5);
        do_reset();
        repeat (3) press(8'h3C, 1);
        repeat (4) press(8'h1B, 4);
        press(8'h1C, 6);

        code = 8'h32;
        rdy  = 1'b1;
        repeat (5) @(negedge clk);
        chk("pulse_before_rst", 64'(restart), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        chk("rst_in_pulse_regs", dut_regs(), exp_regs());
        chk("rst_in_pulse_restart", 64'(restart), 64'(0));
        chk("rst_in_pulse_strobe", 64'(cmd_strobe), 64'(0));
        reset = 1'b0;
        press(8'h32, 9);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 9) c = 8'($urandom);
            else c = codes[$urandom_range(0, 8)];
            press(c, int'($urandom_range(1, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_player_controller.md
Name: kbd_player_controller

Overview:
Keyboard command decoder and playback-control FSM for the flash music player, generalised to multiple tracks, speed levels and configurable address map. It accepts PS/2 scan codes from the keyboard interface (async ready flag), synchronises the flag, decodes one command per key press and drives the playback core's start/end address window, direction, pause, speed select and a multi-cycle restart pulse. It sits between the keyboard receiver and the flash-read/audio address generator.

Parameters:
ADDR_W, 23, width of flash word address outputs
NUM_TRACKS, 4, number of equal-size tracks in flash (>=1)
TRACK_SPAN, 23'h80000, words per track; track t occupies [t*TRACK_SPAN, t*TRACK_SPAN+TRACK_SPAN-1]
RST_PULSE_CYCLES, 2, high width of restart pulse in clk cycles (>=1)
SPEED_LEVELS, 4, number of speed settings (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
kbd_data_ready  in  1  key-valid flag from keyboard receiver, asynchronous to clk, level held while code valid
kbd_code  in  8  scan code, stable while kbd_data_ready high
track_sel  out  TRACK_W  current track, TRACK_W = max(1, clog2(NUM_TRACKS))
start_addr  out  ADDR_W  first address to play (direction-dependent)
end_addr  out  ADDR_W  last address to play (direction-dependent)
direction  out  1  1 = forward, 0 = backward
pause  out  1  1 = paused
speed_sel  out  clog2(SPEED_LEVELS)  speed index, 0 = slowest
restart  out  1  playback-core reload pulse
cmd_strobe  out  1  one-cycle pulse per recognised command

Behaviour:
- Reset values: track_sel 0, direction 1, pause 1, speed_sel 1, restart 0, cmd_strobe 0, start_addr 0, end_addr TRACK_SPAN-1, FSM IDLE, synchroniser flops 0.
- kbd_data_ready passes through a 2-flop synchroniser (rdy_s); FSM uses rdy_s only. kbd_code is captured into a register on the IDLE->DECODE edge.
- States: IDLE: rdy_s=1 -> DECODE. DECODE: look up captured code -> EXEC (recognised) or WAIT_REL (unrecognised, no output change, no strobe). EXEC: apply command, cmd_strobe=1 for this one cycle; -> PULSE if command restarts, else WAIT_REL. PULSE: restart=1 for exactly RST_PULSE_CYCLES cycles (counter), then -> WAIT_REL. WAIT_REL: rdy_s=0 -> IDLE.
- Latency: rdy_s rises N; DECODE N+1; EXEC N+2; register outputs hold new values from N+3; restart high N+3..N+2+RST_PULSE_CYCLES.
- Commands: 8'h2D R restart only; 8'h23 D pause=1; 8'h24 E pause=0; 8'h32 B direction=0 + restart; 8'h2B F direction=1 + restart; 8'h31 N track+1 + restart; 8'h4D P track-1 + restart; 8'h3C U speed+1; 8'h1B S speed-1.
- Track wrap: N from NUM_TRACKS-1 -> 0; P from 0 -> NUM_TRACKS-1. NUM_TRACKS=1: N/P keep track 0 but still restart.
- Speed saturates at 0 and SPEED_LEVELS-1; saturated U/S still give cmd_strobe, no change.
- Address window (registered, updated with track/direction): base = track_sel*TRACK_SPAN, top = base+TRACK_SPAN-1, truncated to ADDR_W. Forward: start=base, end=top. Backward: start=top, end=base.
- pause and speed unaffected by restart commands; restart never alters pause.
- Held key: exactly one command per rdy_s high period; repeats need rdy_s to drop to 0.
- rdy_s falling during DECODE/EXEC/PULSE: command completes; WAIT_REL exits next cycle.
- reset mid-operation (any state incl. PULSE): next cycle all outputs at reset values, restart 0, FSM IDLE; a key still held after reset resynchronises and executes once.

Test Plan:
- Reset then hold ready with 8'h24 for 10 cycles -> pause 1->0 from rdy rise+5 cycles; cmd_strobe one pulse; no restart; second command only after ready drops and rises.
- 8'h32 on track 0 -> direction 0, start_addr 23'h7FFFF, end_addr 0, restart high exactly 2 cycles, pause unchanged.
- 8'h31 four times (NUM_TRACKS=4) -> track_sel 1,2,3,0; forward start_addr 23'h80000,23'h100000,23'h180000,0; restart after each.
- 8'h4D from track 0 with direction 0 -> track_sel 3, start_addr 23'h1FFFFF, end_addr 23'h180000.
- 8'h3C three times from reset -> speed_sel 2,3,3 (3 strobes); 8'h1B four times -> 2,1,0,0.
- Unknown code 8'h1C -> no output change, no strobe; reset asserted during PULSE -> restart 0 and all outputs at reset values next cycle.
